// File: rtl/libfifo_pkg.sv
// Shared fifo types plus the burst reader's state encoding and helper.
package libfifo_pkg;

  // Fifo occupancy flags; the level itself travels separately since its width follows DEPTH
  typedef struct packed {
    logic full;
    logic empty;
  } fill_status_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Number of words the next burst will move: whatever is buffered, capped at the burst length
  function automatic int unsigned min_fill(input int unsigned avail, input int unsigned burst_len);
    return (avail < burst_len) ? avail : burst_len;
  endfunction

endpackage

// File: rtl/fifoConnect.sv
// Connection bundle between a fifo core and its reader/writer.
interface fifoConnect
  import libfifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             read;
  logic             write;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  fill_status_t     fillStatus;
  // Wraps to 0 when the fifo holds exactly DEPTH words; full disambiguates
  logic [LW-1:0]    fillLevel;

  modport reader (output read, output write, output datain,
                  input dataout, input fillStatus, input fillLevel);

  modport core (input read, input write, input datain,
                output dataout, output fillStatus, output fillLevel);

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready register slice. in_ready comes straight from a register so the
// upstream pop decision never depends combinationally on out_ready.
module stream_skid_buffer #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              vld_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] data_p1;
  logic              push;
  logic              pop;

  assign in_ready  = !vld_p1;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign push      = in_valid && !vld_p1;
  assign pop       = vld_p0 && out_ready;

  // Occupancy: p0 is the presented head, p1 the spare that absorbs a word while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= vld_p1 || push || (vld_p0 && !pop);
      vld_p1 <= (vld_p1 && !pop) || (vld_p0 && !pop && push);
    end
  end

  // Head word: only moves when it is free or being taken, so it stays put while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0 <= '0;
    end else if ((!vld_p0 || pop) && (vld_p1 || push)) begin
      data_p0 <= vld_p1 ? data_p1 : in_data;
    end
  end

  // Spare word: captured only when the head is occupied and not leaving
  always_ff @(posedge clk) begin
    if (push && vld_p0 && !pop) begin
      data_p1 <= in_data;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fifo in bursts and emits them as a last-tagged valid/ready stream.
// A burst starts on a full burst's worth of data, an idle timeout with a partial fill, or flush.
module fifo_burst_reader
  import libfifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64,
  parameter int CNTBITS   = 16
) (
  input  logic               clk,
  input  logic               reset,
  fifoConnect.reader         link,
  input  logic               flush,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic [CNTBITS-1:0] burst_count
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(BURST_LEN + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  burst_state_t   state;
  logic [TW-1:0]  timer;
  logic [LW-1:0]  words_left;
  logic [AW-1:0]  avail;
  logic           timeout_hit;
  logic           start_burst;
  logic           pop;
  logic           in_ready;
  logic [WIDTH:0] skid_out;

  // A full fifo reports a wrapped level, so full stands in for DEPTH
  assign avail       = link.fillStatus.full ? AW'(DEPTH) : AW'(link.fillLevel);
  assign timeout_hit = (TIMEOUT != 0) && (timer == TMO_LAST) && (avail != '0);
  assign start_burst = (avail >= AW'(BURST_LEN)) || (flush && (avail != '0)) || timeout_hit;

  assign pop          = (state == BURST) && in_ready && !link.fillStatus.empty &&
                        (words_left != '0) && !reset;
  assign link.read    = pop;
  assign link.write   = 1'b0;
  assign link.datain  = '0;

  // Burst control: launch decision in IDLE, word countdown and completion count in BURST
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      timer       <= '0;
      words_left  <= '0;
      burst_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_burst) begin
            state      <= BURST;
            busy       <= 1'b1;
            timer      <= '0;
            words_left <= LW'(min_fill(int'(avail), BURST_LEN));
          end else if ((avail == '0) || (TIMEOUT == 0)) begin
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BURST: begin
          if (pop) begin
            words_left <= words_left - LW'(1);
            if (words_left == LW'(1)) begin
              state       <= IDLE;
              busy        <= 1'b0;
              burst_count <= burst_count + CNTBITS'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  stream_skid_buffer #(
    .DATA_W (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pop),
    .in_data   ({link.dataout, (words_left == LW'(1))}),
    .in_ready  (in_ready),
    .out_valid (m_valid),
    .out_data  (skid_out),
    .out_ready (m_ready)
  );

  assign m_data = skid_out[WIDTH:1];
  assign m_last = skid_out[0];

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural fifo and a stream scoreboard.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_reset;
  logic        flush;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        busy;
  logic [15:0] burst_count;
  logic        wr_en;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;
  int exp_bursts = 0;
  int hs_cnt = 0;
  int last_cnt = 0;
  int pop_cnt = 0;
  int pop_base;
  int last_base;
  int quiet;

  logic [32:0] exp_q[$];
  logic        hold = 1'b0;
  logic [32:0] hold_word;

  always #5 clk = ~clk;

  fifoConnect #(.WIDTH(32), .DEPTH(32)) link ();

  fifo_burst_reader #(
    .WIDTH(32), .DEPTH(32), .BURST_LEN(8), .TIMEOUT(64), .CNTBITS(16)
  ) dut (
    .clk(clk), .reset(reset), .link(link), .flush(flush),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .burst_count(burst_count)
  );

  // Behavioural fifo, 32 deep, level wraps to 0 when full
  logic [31:0] fmem [32];
  int          wp = 0;
  int          rp = 0;
  int          fcnt = 0;

  assign link.dataout    = fmem[rp];
  assign link.fillStatus = {(fcnt == 32), (fcnt == 0)};
  assign link.fillLevel  = fcnt[4:0];

  always @(posedge clk) begin
    if (fifo_reset) begin
      wp <= 0;
      rp <= 0;
      fcnt <= 0;
      pop_cnt <= 0;
    end else begin
      if (wr_en && fcnt < 32) begin
        fmem[wp] <= wr_data;
        wp <= (wp + 1) % 32;
      end
      if (link.read) begin
        rp <= (rp + 1) % 32;
        pop_cnt <= pop_cnt + 1;
      end
      fcnt <= fcnt + ((wr_en && fcnt < 32) ? 1 : 0) - (link.read ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: stream monitor on the falling edge, then return just after the rising edge
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    chk("read_guard", 64'(link.read && (reset || link.fillStatus.empty)), 64'd0);
    chk("write_zero", 64'(link.write), 64'd0);
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("stall_hold", {31'd0, m_valid, m_last, m_data}, {31'd0, 1'b1, hold_word});
      if (m_valid && m_ready) begin
        hold = 1'b0;
        chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(m_data), 64'(e[31:0]));
          chk("out_last", 64'(m_last), 64'(e[32]));
        end
        hs_cnt++;
        if (m_last) last_cnt++;
      end else if (m_valid) begin
        hold = 1'b1;
        hold_word = {m_last, m_data};
      end else begin
        hold = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic last);
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back({last, d});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk(tag, 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    reset = 1'b1; fifo_reset = 1'b1; flush = 1'b0; m_ready = 1'b1;
    wr_en = 1'b0; wr_data = '0;
    tick(); tick();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_burst_count", 64'(burst_count), 64'd0);
    chk("rst_read", 64'(link.read), 64'd0);
    reset = 1'b0; fifo_reset = 1'b0;
    tick();

    // 1: exactly one burst's worth
    for (int i = 0; i < 8; i++) wr(32'(i), i == 7);
    exp_bursts++;
    drain("t1_drain", 40);
    chk("t1_burst_count", 64'(burst_count), 64'(exp_bursts));
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: partial fill released by the idle timeout
    wr(32'h10, 1'b0); wr(32'h11, 1'b0); wr(32'h12, 1'b1);
    exp_bursts++;
    quiet = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (m_valid || busy) quiet = 0;
    end
    chk("t2_quiet", 64'(quiet), 64'd1);
    for (int i = 0; i < 20 && !busy; i++) tick();
    chk("t2_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5 && !m_valid; i++) tick();
    chk("t2_first_valid", 64'(m_valid), 64'd1);
    chk("t2_busy_in_burst", 64'(busy), 64'd1);
    drain("t2_drain", 20);
    chk("t2_burst_count", 64'(burst_count), 64'(exp_bursts));

    // 3: 20 words -> 8, 8, then a flushed burst of 4
    for (int i = 0; i < 20; i++) wr(32'(100 + i), (i == 7) || (i == 15) || (i == 19));
    exp_bursts += 2;
    for (int i = 0; i < 60 && burst_count != 16'(exp_bursts); i++) tick();
    chk("t3_two_bursts", 64'(burst_count), 64'(exp_bursts));
    for (int i = 0; i < 4; i++) tick();
    chk("t3_remainder_idle", 64'(busy), 64'd0);
    chk("t3_remainder_quiet", 64'(m_valid), 64'd0);
    chk("t3_remainder_held", 64'(exp_q.size()), 64'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_start", 64'(busy), 64'd1);
    exp_bursts++;
    drain("t3_drain", 30);
    chk("t3_burst_count", 64'(burst_count), 64'(exp_bursts));

    // 4: short flushed burst against a toggling consumer
    wr(32'hA, 1'b0); wr(32'hB, 1'b0); wr(32'hC, 1'b0); wr(32'hD, 1'b1);
    exp_bursts++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_start", 64'(busy), 64'd1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    drain("t4_drain", 10);
    chk("t4_burst_count", 64'(burst_count), 64'(exp_bursts));

    // 5: fifo filled to DEPTH while the reader is held in reset
    reset = 1'b1; fifo_reset = 1'b1;
    tick();
    fifo_reset = 1'b0;
    for (int i = 0; i < 32; i++) wr(32'(300 + i), (i % 8) == 7);
    chk("t5_read_in_reset", 64'(link.read), 64'd0);
    reset = 1'b0;
    exp_bursts = 4;
    tick();
    chk("t5_full_start", 64'(busy), 64'd1);
    drain("t5_drain", 100);
    chk("t5_burst_count", 64'(burst_count), 64'(exp_bursts));

    // 6: reset after three pops of an eight-word burst
    pop_base = pop_cnt;
    for (int i = 0; i < 8; i++) wr(32'(200 + i), i == 7);
    for (int i = 0; i < 20 && (pop_cnt - pop_base) < 3; i++) tick();
    chk("t6_three_pops", 64'(pop_cnt - pop_base), 64'd3);
    last_base = last_cnt;
    reset = 1'b1; fifo_reset = 1'b1;
    #1;
    chk("t6_read_gated", 64'(link.read), 64'd0);
    tick();
    chk("t6_m_valid", 64'(m_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_burst_count", 64'(burst_count), 64'd0);
    chk("t6_read", 64'(link.read), 64'd0);
    chk("t6_m_data", 64'(m_data), 64'd0);
    exp_q.delete();
    reset = 1'b0; fifo_reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_last", 64'(last_cnt), 64'(last_base));
    chk("t6_quiet", 64'(m_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
